// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the EX-stage hazard/forwarding controller.
// Slot records mirror the pipeline occupants; slot_hit() is the common match rule.
package riscv_pipe_pkg;

    localparam int SLOT_AW = 5;
    localparam int CNT_W   = 2;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALU_A_REG  = 2'b00;
    localparam logic [1:0] ALU_A_PC   = 2'b01;
    localparam logic [1:0] ALU_A_ZERO = 2'b10;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic               valid;
        logic [SLOT_AW-1:0] rd;
        logic               reg_write;
        logic               mem_read;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    typedef enum logic {
        ST_RUN,
        ST_LSTALL
    } ctrl_state_t;

    // loads_ok=0 masks a load occupant: its data is not yet available for bypass.
    function automatic logic slot_hit(input slot_t s, input logic [SLOT_AW-1:0] rs,
                                      input logic loads_ok);
        return s.valid & s.reg_write & (s.rd == rs) & (s.rd != '0) & (loads_ok | ~s.mem_read);
    endfunction

    function automatic logic [1:0] alu_a_sel(input logic [6:0] opcode);
        logic [1:0] sel;
        sel = ALU_A_REG;
        if (opcode == OP_LUI) begin
            sel = ALU_A_ZERO;
        end else if ((opcode == OP_AUIPC) || (opcode == OP_JAL)) begin
            sel = ALU_A_PC;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Combinational forwarding priority for one source operand: youngest producer wins.
// Zero latency; no flow control.
module fwd_select
    import riscv_pipe_pkg::*;
(
    input  logic [SLOT_AW-1:0] rs,
    input  slot_t              ex_slot,
    input  slot_t              mem_slot,
    output logic [1:0]         sel
);

    always_comb begin
        sel = FWD_RF;
        if (slot_hit(ex_slot, rs, 1'b0)) begin
            sel = FWD_EXMEM;
        end else if (slot_hit(mem_slot, rs, 1'b1)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// EX-stage operand-mux controller: load-use stall, redirect flush, registered ALU selects (1 cycle).
// Stall/flush/bubble are combinational; a taken branch overrides any stall in progress.
module hazard_forward_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int REG_AW   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [6:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              flush_ifid,
    output logic              bubble_idex,
    output logic [1:0]        ex_alu_src_a,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b
);

    // The WB occupant is never tracked: the regfile writes before it is read.
    slot_t              ex_slot;
    slot_t              mem_slot;
    slot_t              id_slot;
    ctrl_state_t        state;
    ctrl_state_t        state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [SLOT_AW-1:0] rs1_x;
    logic [SLOT_AW-1:0] rs2_x;
    logic               load_use;
    logic               advance;
    logic [1:0]         src_a_id;
    logic [1:0]         fwd_a_raw;
    logic [1:0]         fwd_b_raw;
    logic [1:0]         fwd_a_id;
    logic [1:0]         fwd_b_id;

    assign rs1_x = SLOT_AW'(id_rs1);
    assign rs2_x = SLOT_AW'(id_rs2);

    assign id_slot = '{valid:     1'b1,
                       rd:        SLOT_AW'(id_rd),
                       reg_write: id_reg_write,
                       mem_read:  id_mem_read};

    assign load_use = id_valid & ex_slot.mem_read &
                      ((id_use_rs1 & slot_hit(ex_slot, rs1_x, 1'b1)) |
                       (id_use_rs2 & slot_hit(ex_slot, rs2_x, 1'b1)));

    fwd_select u_fwd_a (
        .rs       (rs1_x),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .sel      (fwd_a_raw)
    );

    fwd_select u_fwd_b (
        .rs       (rs2_x),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .sel      (fwd_b_raw)
    );

    assign src_a_id = alu_a_sel(id_opcode);
    // Operand A bypass only matters when the mux actually picks the register path.
    assign fwd_a_id = (id_use_rs1 && (src_a_id == ALU_A_REG)) ? fwd_a_raw : FWD_RF;
    assign fwd_b_id = id_use_rs2 ? fwd_b_raw : FWD_RF;

    always_comb begin
        stall       = 1'b0;
        flush_ifid  = 1'b0;
        bubble_idex = 1'b0;
        state_nxt   = state;
        cnt_nxt     = cnt;
        if (reset) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
        end else if (ex_branch_taken) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
            state_nxt   = ST_RUN;
            cnt_nxt     = '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (load_use) begin
                        stall       = 1'b1;
                        bubble_idex = 1'b1;
                        cnt_nxt     = CNT_W'(LOAD_LAT - 1);
                        state_nxt   = (LOAD_LAT == 1) ? ST_RUN : ST_LSTALL;
                    end
                end
                ST_LSTALL: begin
                    stall       = 1'b1;
                    bubble_idex = 1'b1;
                    // Total stall length equals LOAD_LAT: leave as the count reaches zero.
                    if (cnt <= CNT_W'(1)) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign advance = id_valid & ~stall & ~ex_branch_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RUN;
            cnt          <= '0;
            ex_slot      <= SLOT_EMPTY;
            mem_slot     <= SLOT_EMPTY;
            ex_alu_src_a <= ALU_A_REG;
            ex_fwd_a     <= FWD_RF;
            ex_fwd_b     <= FWD_RF;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            mem_slot <= ex_slot;
            if (advance) begin
                ex_slot      <= id_slot;
                ex_alu_src_a <= src_a_id;
                ex_fwd_a     <= fwd_a_id;
                ex_fwd_b     <= fwd_b_id;
            end else begin
                ex_slot      <= SLOT_EMPTY;
                ex_alu_src_a <= ALU_A_REG;
                ex_fwd_a     <= FWD_RF;
                ex_fwd_b     <= FWD_RF;
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus,
// each compared every cycle against an in-flight-instruction model.
module tb_hazard_forward_ctrl;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_ALU   = 7'b0110011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       ex_branch_taken;

    logic       st [2];
    logic       fl [2];
    logic       bu [2];
    logic [1:0] sa [2];
    logic [1:0] fa [2];
    logic [1:0] fb [2];

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.LOAD_LAT(1), .REG_AW(5)) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .stall(st[0]), .flush_ifid(fl[0]), .bubble_idex(bu[0]),
        .ex_alu_src_a(sa[0]), .ex_fwd_a(fa[0]), .ex_fwd_b(fb[0])
    );

    hazard_forward_ctrl #(.LOAD_LAT(3), .REG_AW(5)) dut3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .stall(st[1]), .flush_ifid(fl[1]), .bubble_idex(bu[1]),
        .ex_alu_src_a(sa[1]), .ex_fwd_a(fa[1]), .ex_fwd_b(fb[1])
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: what occupies EX and MEM, plus how many more stall cycles are owed.
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit ld;
    } rec_t;

    rec_t m_ex   [2];
    rec_t m_mem  [2];
    int   m_left [2];
    int   m_sa   [2];
    int   m_fa   [2];
    int   m_fb   [2];
    int   lat    [2] = '{1, 3};

    function automatic bit hits(rec_t r, int rs);
        return r.v && r.rw && (r.rd == rs) && (r.rd != 0);
    endfunction

    function automatic int mfwd(int k, int rs);
        if (hits(m_ex[k], rs))  return 1;
        if (hits(m_mem[k], rs)) return 2;
        return 0;
    endfunction

    task automatic step();
        #2;
        for (int k = 0; k < 2; k++) begin
            bit   lu, e_st, e_fl, e_bu, adv;
            int   e_sa, e_fa, e_fb;
            rec_t empty_r;
            string pfx;
            pfx = $sformatf("lat%0d", lat[k]);
            empty_r = '{v: 0, rd: 0, rw: 0, ld: 0};
            lu = id_valid && m_ex[k].ld &&
                 ((id_use_rs1 && hits(m_ex[k], int'(id_rs1))) ||
                  (id_use_rs2 && hits(m_ex[k], int'(id_rs2))));
            e_st = 0; e_fl = 0; e_bu = 0;
            if (!reset) begin
                if (ex_branch_taken) begin
                    e_fl = 1; e_bu = 1;
                end else if (m_left[k] > 0 || lu) begin
                    e_st = 1; e_bu = 1;
                end
            end
            check_eq({pfx, " stall"},  32'(st[k]), 32'(e_st));
            check_eq({pfx, " flush"},  32'(fl[k]), 32'(e_fl));
            check_eq({pfx, " bubble"}, 32'(bu[k]), 32'(e_bu));

            if (id_opcode == OPC_LUI) e_sa = 2;
            else if (id_opcode == OPC_AUIPC || id_opcode == OPC_JAL) e_sa = 1;
            else e_sa = 0;
            e_fa = (id_use_rs1 && e_sa == 0) ? mfwd(k, int'(id_rs1)) : 0;
            e_fb = id_use_rs2 ? mfwd(k, int'(id_rs2)) : 0;

            if (reset) begin
                m_ex[k] = empty_r; m_mem[k] = empty_r; m_left[k] = 0;
                m_sa[k] = 0; m_fa[k] = 0; m_fb[k] = 0;
            end else begin
                adv = id_valid && !e_st && !ex_branch_taken;
                m_mem[k] = m_ex[k];
                if (adv) m_ex[k] = '{v: 1, rd: int'(id_rd), rw: id_reg_write, ld: id_mem_read};
                else     m_ex[k] = empty_r;
                m_sa[k] = adv ? e_sa : 0;
                m_fa[k] = adv ? e_fa : 0;
                m_fb[k] = adv ? e_fb : 0;
                if (ex_branch_taken)  m_left[k] = 0;
                else if (m_left[k] > 0) m_left[k]--;
                else if (lu)          m_left[k] = lat[k] - 1;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            string pfx;
            pfx = $sformatf("lat%0d", lat[k]);
            check_eq({pfx, " ex_alu_src_a"}, 32'(sa[k]), 32'(m_sa[k]));
            check_eq({pfx, " ex_fwd_a"},     32'(fa[k]), 32'(m_fa[k]));
            check_eq({pfx, " ex_fwd_b"},     32'(fb[k]), 32'(m_fb[k]));
        end
    endtask

    // Present one ID instruction for n cycles.
    task automatic put(input int n, input bit v, input logic [6:0] op, input int r1, input int r2,
                       input int rd, input bit u1, input bit u2, input bit rw, input bit mr,
                       input bit br);
        for (int i = 0; i < n; i++) begin
            id_valid = v; id_opcode = op;
            id_rs1 = 5'(r1); id_rs2 = 5'(r2); id_rd = 5'(rd);
            id_use_rs1 = u1; id_use_rs2 = u2; id_reg_write = rw; id_mem_read = mr;
            ex_branch_taken = br;
            step();
        end
    endtask

    task automatic nops(input int n);
        put(n, 0, OPC_ALU, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [6:0] op_tab [5] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_ALU, OPC_LD};

    initial begin
        reset = 1'b1;
        nops(2);
        reset = 1'b0;
        nops(1);

        // lw x5 ; add x6,x5,x1 held while stalled
        put(1, 1, OPC_LD,  1, 0, 5, 1, 0, 1, 1, 0);
        put(4, 1, OPC_ALU, 5, 1, 6, 1, 1, 1, 0, 0);
        nops(3);
        // add x3 ; sub x4,x3,x3
        put(1, 1, OPC_ALU, 1, 2, 3, 1, 1, 1, 0, 0);
        put(1, 1, OPC_ALU, 3, 3, 4, 1, 1, 1, 0, 0);
        nops(2);
        // add x3 ; nop ; or x7,x3,x2 ; then writes to x0
        put(1, 1, OPC_ALU, 1, 2, 3, 1, 1, 1, 0, 0);
        nops(1);
        put(1, 1, OPC_ALU, 3, 2, 7, 1, 1, 1, 0, 0);
        put(1, 1, OPC_LD,  1, 0, 0, 1, 0, 1, 1, 0);
        put(1, 1, OPC_ALU, 0, 0, 4, 1, 1, 1, 0, 0);
        nops(2);
        // redirect during a load-use stall
        put(1, 1, OPC_LD,  1, 0, 5, 1, 0, 1, 1, 0);
        put(1, 1, OPC_ALU, 5, 1, 6, 1, 1, 1, 0, 0);
        put(1, 1, OPC_ALU, 5, 1, 6, 1, 1, 1, 0, 1);
        put(2, 1, OPC_ALU, 5, 1, 6, 1, 1, 1, 0, 0);
        nops(3);
        // lui/auipc/jal with a matching rs1 field
        put(1, 1, OPC_ALU, 1, 2, 5, 1, 1, 1, 0, 0);
        put(1, 1, OPC_LUI,   5, 0, 8, 1, 0, 1, 0, 0);
        put(1, 1, OPC_AUIPC, 5, 0, 9, 1, 0, 1, 0, 0);
        put(1, 1, OPC_JAL,   9, 0, 1, 1, 0, 1, 0, 0);
        nops(2);
        // long load-use interrupted by reset in its second cycle
        put(1, 1, OPC_LD,  1, 0, 5, 1, 0, 1, 1, 0);
        put(1, 1, OPC_ALU, 5, 1, 6, 1, 1, 1, 0, 0);
        reset = 1'b1;
        put(1, 1, OPC_ALU, 5, 1, 6, 1, 1, 1, 0, 0);
        reset = 1'b0;
        put(3, 1, OPC_ALU, 5, 1, 6, 1, 1, 1, 0, 0);
        nops(3);

        for (int i = 0; i < 600; i++) begin
            logic [6:0] op;
            bit ld;
            op = op_tab[$urandom_range(0, 4)];
            ld = (op == OPC_LD) || ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 59) == 0);
            put(1, ($urandom_range(0, 9) != 0), op,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 4) != 0), ld, ($urandom_range(0, 11) == 0));
        end
        reset = 1'b0;
        nops(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
